// File: rtl/sensor_rr_scheduler_if.sv
// Handshake bundle between the sensor scheduler and the shared processing unit.
// The master side is the scheduler, the slave side is the processing unit that
// consumes issued samples and returns decisions.
interface sensor_rr_scheduler_if #(
  parameter int N_CH = 4,
  parameter int DW   = 16
);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic           proc_valid;
  logic           proc_ready;
  logic [DW-1:0]  proc_data;
  logic [CHW-1:0] proc_ch;
  logic           proc_done;
  logic           proc_decision;
  logic           dec_valid;
  logic [CHW-1:0] dec_ch;
  logic           dec_value;

  modport master (
    output proc_valid, proc_data, proc_ch, dec_valid, dec_ch, dec_value,
    input  proc_ready, proc_done, proc_decision
  );

  modport slave (
    input  proc_valid, proc_data, proc_ch, dec_valid, dec_ch, dec_value,
    output proc_ready, proc_done, proc_decision
  );
endinterface

// File: rtl/sensor_rr_scheduler.sv
// Round-robin scheduler sharing one processing unit between N_CH sensor channels.
// Each channel owns a one-deep holding register; a pending, enabled channel is
// granted in rotation, its sample is offered over valid/ready, and the returned
// decision is tagged with the channel. Overruns and timeouts are sticky flags.
module sensor_rr_scheduler #(
  parameter int N_CH    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*DW-1:0]   ch_data,
  input  logic [N_CH-1:0]      ch_valid,
  input  logic [N_CH-1:0]      ch_enable,
  input  logic                 clear_err,
  sensor_rr_scheduler_if.master pif,
  output logic [N_CH-1:0]      overrun,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   hold [N_CH];
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] cap;
  logic [N_CH-1:0] gnt_clr;
  logic [N_CH-1:0] ovr_evt;
  logic [CHW-1:0]  last_grant;
  logic [CHW-1:0]  grant;
  logic [CHW-1:0]  sel;
  logic [CHW-1:0]  idx;
  logic            sel_found;
  logic [DW-1:0]   issue_reg;
  logic [TW-1:0]   timer;
  logic            do_grant;
  logic            do_accept;
  logic            do_done;
  logic            do_timeout;
  logic            dec_valid_q;
  logic [CHW-1:0]  dec_ch_q;
  logic            dec_value_q;

  assign req = pend & ch_enable;
  assign cap = ch_valid & ch_enable;

  // Rotating priority search starting just after the last served channel.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    idx       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CHW'((int'(last_grant) + k) % N_CH);
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel       = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the single-cycle control events of each transition.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_accept  = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (pif.proc_ready) begin
          do_accept  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (pif.proc_done) begin
          do_done    = 1'b1;
          state_next = IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Granted channel's pend bit is released; a capture in the same cycle still wins.
  always_comb begin
    gnt_clr = '0;
    if (do_grant) gnt_clr[sel] = 1'b1;
    ovr_evt = cap & pend & ~gnt_clr;
  end

  // Per-channel holding registers: newest sample always overwrites the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < N_CH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cap[i]) begin
          hold[i] <= ch_data[i*DW +: DW];
          pend[i] <= 1'b1;
        end else if (gnt_clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Grant bookkeeping, issued sample snapshot and the WAIT cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= CHW'(N_CH - 1);
      grant      <= '0;
      issue_reg  <= '0;
      timer      <= '0;
    end else begin
      if (do_grant) begin
        grant     <= sel;
        issue_reg <= hold[sel];
      end
      if (do_accept)
        timer <= '0;
      else if (state == WAIT && !do_done && !do_timeout)
        timer <= timer + 1'b1;
      if (do_done || do_timeout)
        last_grant <= grant;
    end
  end

  // Registered result strobe; channel and value hold between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid_q <= 1'b0;
      dec_ch_q    <= '0;
      dec_value_q <= 1'b0;
    end else begin
      dec_valid_q <= do_done;
      if (do_done) begin
        dec_ch_q    <= grant;
        dec_value_q <= pif.proc_decision;
      end
    end
  end

  // Sticky error flags; a fresh event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= '0;
      timeout_err <= 1'b0;
    end else begin
      overrun     <= (overrun & ~{N_CH{clear_err}}) | ovr_evt;
      timeout_err <= (timeout_err & ~clear_err) | do_timeout;
    end
  end

  assign pif.proc_valid = (state == ISSUE);
  assign pif.proc_data  = issue_reg;
  assign pif.proc_ch    = grant;
  assign pif.dec_valid  = dec_valid_q;
  assign pif.dec_ch     = dec_ch_q;
  assign pif.dec_value  = dec_value_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_sensor_rr_scheduler.sv
// Directed testbench for sensor_rr_scheduler: reset, rotation order, overrun,
// same-cycle capture at grant, timeout, channel masking and mid-WAIT reset.
module tb_sensor_rr_scheduler;

  localparam int N_CH    = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH*DW-1:0] ch_data;
  logic [N_CH-1:0]    ch_valid;
  logic [N_CH-1:0]    ch_enable;
  logic               clear_err;
  logic [N_CH-1:0]    overrun;
  logic               timeout_err;
  logic               busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int wait_cycles;
  logic dec_seen;

  sensor_rr_scheduler_if #(.N_CH(N_CH), .DW(DW)) pif ();

  sensor_rr_scheduler #(.N_CH(N_CH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .ch_enable   (ch_enable),
    .clear_err   (clear_err),
    .pif         (pif),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the design never lets the sequence advance.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One-cycle strobe on the channels in mask; returns at the following negedge.
  task automatic apply_stimulus(input logic [N_CH-1:0] mask, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [DW-1:0] d3);
    ch_data  = {d3, d2, d1, d0};
    ch_valid = mask;
    tick();
    ch_valid = '0;
  endtask

  task automatic wait_issue(input string tag, input int exp_ch, input logic [DW-1:0] exp_data);
    for (int n = 0; n < 20 && !pif.proc_valid; n++) tick();
    check_output({tag, "_valid"}, pif.proc_valid, 1);
    check_output({tag, "_ch"}, pif.proc_ch, exp_ch);
    check_output({tag, "_data"}, pif.proc_data, exp_data);
  endtask

  task automatic accept();
    pif.proc_ready = 1'b1;
    tick();
    pif.proc_ready = 1'b0;
  endtask

  task automatic finish_wait(input string tag, input int exp_ch, input logic decision);
    pif.proc_done     = 1'b1;
    pif.proc_decision = decision;
    tick();
    pif.proc_done     = 1'b0;
    pif.proc_decision = 1'b0;
    check_output({tag, "_dec_valid"}, pif.dec_valid, 1);
    check_output({tag, "_dec_ch"}, pif.dec_ch, exp_ch);
    check_output({tag, "_dec_value"}, pif.dec_value, decision);
  endtask

  task automatic serve(input string tag, input int exp_ch, input logic [DW-1:0] exp_data,
                       input logic decision);
    wait_issue(tag, exp_ch, exp_data);
    accept();
    finish_wait(tag, exp_ch, decision);
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst               = 1'b1;
    ch_data           = '0;
    ch_valid          = '0;
    ch_enable         = 4'hF;
    clear_err         = 1'b0;
    pif.proc_ready    = 1'b0;
    pif.proc_done     = 1'b0;
    pif.proc_decision = 1'b0;

    // Step 1: reset values, latency and first result.
    apply_reset();
    check_output("rst_proc_valid", pif.proc_valid, 0);
    check_output("rst_dec_valid", pif.dec_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_timeout", timeout_err, 0);
    apply_stimulus(4'b0001, 16'h0070, 16'h0, 16'h0, 16'h0);
    check_output("s1_lat_n1_valid", pif.proc_valid, 0);
    tick();
    check_output("s1_lat_n2_valid", pif.proc_valid, 1);
    check_output("s1_lat_n2_ch", pif.proc_ch, 0);
    check_output("s1_lat_n2_data", pif.proc_data, 16'h0070);
    accept();
    check_output("s1_wait_valid", pif.proc_valid, 0);
    check_output("s1_wait_busy", busy, 1);
    finish_wait("s1", 0, 1'b0);
    tick();
    check_output("s1_dec_pulse", pif.dec_valid, 0);
    check_output("s1_idle_busy", busy, 0);

    // Step 2: rotation order after reset, then wrap from channel 3.
    apply_reset();
    apply_stimulus(4'b1111, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    serve("s2_c0", 0, 16'h0011, 1'b1);
    serve("s2_c1", 1, 16'h0022, 1'b0);
    serve("s2_c2", 2, 16'h0033, 1'b1);
    serve("s2_c3", 3, 16'h0044, 1'b0);
    apply_stimulus(4'b0101, 16'h0055, 16'h0, 16'h0066, 16'h0);
    serve("s2_w0", 0, 16'h0055, 1'b1);
    serve("s2_w2", 2, 16'h0066, 1'b0);

    // Step 3: overrun on ch1 while ch0 is stalled, then clear.
    apply_stimulus(4'b0001, 16'h00C0, 16'h0, 16'h0, 16'h0);
    wait_issue("s3_c0", 0, 16'h00C0);
    apply_stimulus(4'b0010, 16'h0, 16'h00A1, 16'h0, 16'h0);
    check_output("s3_ovr_first", overrun, 4'b0000);
    apply_stimulus(4'b0010, 16'h0, 16'h00B2, 16'h0, 16'h0);
    check_output("s3_ovr_second", overrun, 4'b0010);
    tick();
    tick();
    check_output("s3_stall_valid", pif.proc_valid, 1);
    check_output("s3_stall_data", pif.proc_data, 16'h00C0);
    accept();
    finish_wait("s3_c0", 0, 1'b1);
    serve("s3_c1", 1, 16'h00B2, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_output("s3_ovr_clear", overrun, 4'b0000);

    // Step 3b: capture on ch2 in the same cycle it is granted.
    ch_data  = {16'h0, 16'h00E1, 16'h0, 16'h0};
    ch_valid = 4'b0100;
    tick();
    ch_data  = {16'h0, 16'h00E2, 16'h0, 16'h0};
    tick();
    ch_valid = '0;
    check_output("s3b_issue_old", pif.proc_data, 16'h00E1);
    check_output("s3b_no_ovr", overrun, 4'b0000);
    serve("s3b_first", 2, 16'h00E1, 1'b0);
    serve("s3b_second", 2, 16'h00E2, 1'b1);
    check_output("s3b_no_ovr_end", overrun, 4'b0000);

    // Step 4: processing timeout on ch3, then ch0 is still served.
    apply_stimulus(4'b1001, 16'h00D0, 16'h0, 16'h0, 16'h00D3);
    wait_issue("s4_c3", 3, 16'h00D3);
    accept();
    wait_cycles = 0;
    dec_seen    = 1'b0;
    while (busy && wait_cycles < 40) begin
      if (pif.dec_valid) dec_seen = 1'b1;
      wait_cycles++;
      tick();
    end
    check_output("s4_wait_len", wait_cycles, TIMEOUT);
    check_output("s4_no_dec", dec_seen, 0);
    check_output("s4_dec_after", pif.dec_valid, 0);
    check_output("s4_timeout_flag", timeout_err, 1);
    serve("s4_c0", 0, 16'h00D0, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_output("s4_timeout_clear", timeout_err, 0);

    // Step 5: masked capture and a disabled pending channel.
    ch_enable = 4'b0111;
    apply_stimulus(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0099);
    tick();
    tick();
    check_output("s5_masked_valid", pif.proc_valid, 0);
    check_output("s5_masked_busy", busy, 0);
    apply_stimulus(4'b0100, 16'h0, 16'h0, 16'h0052, 16'h0);
    wait_issue("s5_c2", 2, 16'h0052);
    apply_stimulus(4'b0010, 16'h0, 16'h0051, 16'h0, 16'h0);
    ch_enable = 4'b0101;
    accept();
    finish_wait("s5_c2", 2, 1'b0);
    for (int n = 0; n < 4; n++) tick();
    check_output("s5_disabled_valid", pif.proc_valid, 0);
    check_output("s5_disabled_busy", busy, 0);
    ch_enable = 4'b0111;
    serve("s5_c1", 1, 16'h0051, 1'b1);
    ch_enable = 4'b1111;
    for (int n = 0; n < 3; n++) tick();
    check_output("s5_ch3_dropped", pif.proc_valid, 0);

    // Step 6: reset during WAIT drops the in-flight sample.
    apply_stimulus(4'b0001, 16'h0060, 16'h0, 16'h0, 16'h0);
    wait_issue("s6_c0", 0, 16'h0060);
    accept();
    check_output("s6_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check_output("s6_rst_valid", pif.proc_valid, 0);
    check_output("s6_rst_dec", pif.dec_valid, 0);
    check_output("s6_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    pif.proc_done     = 1'b1;
    pif.proc_decision = 1'b1;
    tick();
    pif.proc_done     = 1'b0;
    pif.proc_decision = 1'b0;
    check_output("s6_late_done", pif.dec_valid, 0);
    tick();
    check_output("s6_late_done2", pif.dec_valid, 0);
    check_output("s6_idle_busy", busy, 0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
